// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction-fetch sequencer driving the PC and the IF/ID pipeline buffer
module fetch_ctrl #(
  parameter logic [7:0] PC_STEP  = 8'h02,
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       stall,
  input  logic       br_taken,
  input  logic [7:0] br_target,
  input  logic       halt,
  output logic [7:0] pc_out,
  output logic       pc_we,
  output logic       ifid_we,
  output logic       ifid_flush,
  output logic [2:0] state_out,
  output logic [7:0] fetch_cnt
);
  typedef enum logic [2:0] {IDLE = 3'd0, FETCH = 3'd1, STALL = 3'd2, FLUSH = 3'd3, HALT = 3'd4} state_t;
  state_t     state_q, state_d;
  logic [7:0] pc_q, pc_d, cnt_q, cnt_d;
  logic [7:0] br_pc;
  assign br_pc     = {br_target[7:1], 1'b0};
  assign pc_out    = pc_q;
  assign fetch_cnt = cnt_q;
  assign state_out = state_q;
  // state, PC and fetch counter registers; reset abandons any in-flight operation
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      cnt_q   <= 8'h00;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
    end
  end
  // next-state, PC update and pipeline enables; halt beats branch beats stall
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    cnt_d      = cnt_q;
    pc_we      = 1'b0;
    ifid_we    = 1'b0;
    ifid_flush = 1'b0;
    case (state_q)
      IDLE:  state_d = start ? FETCH : IDLE;
      FETCH: begin
        pc_we      = !halt && !stall;
        ifid_we    = !halt && !stall && !br_taken;
        ifid_flush = br_taken && !halt;
        if (halt) state_d = HALT;
        else if (br_taken) begin
          pc_d    = br_pc;
          state_d = FLUSH;
        end else if (stall) state_d = STALL;
        else begin
          pc_d  = pc_q + PC_STEP;
          cnt_d = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'h01;
        end
      end
      STALL: begin
        ifid_flush = br_taken && !halt;
        if (halt) state_d = HALT;
        else if (br_taken) begin
          pc_d    = br_pc;
          state_d = FLUSH;
        end else if (!stall) state_d = FETCH;
      end
      FLUSH: begin
        ifid_flush = 1'b1;
        state_d    = halt ? HALT : FETCH;
      end
      HALT:    state_d = HALT;
      default: state_d = IDLE;
    endcase
  end
endmodule
